// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Two-channel UART baud timing generator. TX ticks mark the end of
//            each bit, RX ticks mark the bit centre. Each channel counts bits
//            per frame and flags frame completion. The bit divisor can be
//            reloaded at runtime while both channels are idle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FRAME_BITS = 10,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tx_run,
  input  logic             rx_run,
  input  logic             rx_resync,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             tx_tick,
  output logic             rx_tick,
  output logic             tx_done,
  output logic             rx_done,
  output logic             tx_busy,
  output logic             rx_busy,
  output logic             div_err
);

  localparam logic [DIV_W-1:0]   c_BIT_DIV  = DIV_W'(CLK_HZ / BAUD);
  localparam int                 c_IDX_W    = $clog2(FRAME_BITS + 1);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [DIV_W-1:0]      r_bit_div;
  logic [DIV_W-1:0]      w_half;
  logic [1:0][DIV_W-1:0] w_target;
  logic [1:0]            w_run;
  logic [1:0]            w_resync;
  logic [1:0]            w_idle;
  logic [1:0]            w_tick;
  logic [1:0]            w_done;
  logic [1:0]            w_busy;
  logic                  w_load_ok;
  logic                  r_div_err;

  // The counter is compared before it advances, so a match at value T yields
  // a registered tick T+1 cycles after the channel leaves IDLE (or after a
  // resync). Hence the end-of-bit target is bit_div-1 and the centre is half-1.
  assign w_half      = r_bit_div >> 1;
  assign w_target[0] = r_bit_div - DIV_W'(1);
  assign w_target[1] = w_half - DIV_W'(1);
  assign w_run       = {rx_run, tx_run};
  assign w_resync    = {rx_resync, 1'b0};

  // Divisor changes are only safe when neither channel is mid-bit.
  assign w_load_ok = div_load && (&w_idle) && (div_in >= DIV_W'(2));

  // Divisor register and rejected-load error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_div <= c_BIT_DIV;
      r_div_err <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_bit_div <= div_in;
      end
      r_div_err <= en && div_load && !w_load_ok;
    end
  end

  // Channel 0 is TX (end-of-bit target), channel 1 is RX (mid-bit target)
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic               r_tick;
    logic               r_done;
    logic               r_busy;
    logic               w_tick_nxt;
    logic               w_done_nxt;

    // Next-state, counter, bit index and pulse decode
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_tick_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      if (!en) begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (w_run[gi]) begin
              w_state_nxt = S_RUN;
            end
          end
          S_RUN: begin
            if (!w_run[gi]) begin
              // Abort: drop the frame without a done pulse
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
              w_idx_nxt   = '0;
            end else if (w_resync[gi]) begin
              // Realign phase; resync beats a coincident tick
              w_cnt_nxt = '0;
            end else begin
              if (r_cnt == w_target[0]) begin
                w_cnt_nxt = '0;
              end else begin
                w_cnt_nxt = r_cnt + DIV_W'(1);
              end
              if (r_cnt == w_target[gi]) begin
                w_tick_nxt = 1'b1;
                if (r_idx == c_LAST_IDX) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_HOLD;
                  w_cnt_nxt   = '0;
                  w_idx_nxt   = '0;
                end else begin
                  w_idx_nxt = r_idx + c_IDX_W'(1);
                end
              end
            end
          end
          S_HOLD: begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            if (!w_run[gi]) begin
              w_state_nxt = S_IDLE;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
          end
        endcase
      end
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_tick  <= 1'b0;
        r_done  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_idx   <= w_idx_nxt;
        r_tick  <= w_tick_nxt;
        r_done  <= w_done_nxt;
        r_busy  <= en && (r_state == S_RUN);
      end
    end

    assign w_idle[gi] = (r_state == S_IDLE);
    assign w_tick[gi] = r_tick;
    assign w_done[gi] = r_done;
    assign w_busy[gi] = r_busy;
  end

  assign tx_tick = w_tick[0];
  assign rx_tick = w_tick[1];
  assign tx_done = w_done[0];
  assign rx_done = w_done[1];
  assign tx_busy = w_busy[0];
  assign rx_busy = w_busy[1];
  assign div_err = r_div_err;

endmodule
`default_nettype wire
